// File: rtl/tms_rom_arbiter.sv
// TMS1x00 program-memory owner: Wishbone image load/verify, core boot sequencing,
// and CPU-priority sharing of the single-port program memory while the core runs.
module tms_rom_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic              cpu_rom_req,
  input  logic [ADDR_W-1:0] cpu_rom_addr,
  output logic [DATA_W-1:0] cpu_rom_data,
  output logic              cpu_rom_valid,
  output logic              cpu_rst_n,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int OFF_W = ADDR_W + 2;
  localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(3'd0);
  localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(3'd4);
  localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  // Running byte checksum of the loaded image, modulo 2^16.
  function automatic logic [15:0] sum_add(input logic [15:0] sum, input logic [DATA_W-1:0] b);
    return sum + 16'(b);
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  hold_cnt_r;
  logic              ack_r;
  logic              rd_mem_r;
  logic [31:0]       reg_rdata_r;
  logic              ctrl_wr_r;
  logic              ctrl_run_r;
  logic              ctrl_clr_r;
  logic              run_r;
  logic              cpu_valid_r;
  logic              cpu_rst_n_r;
  logic [15:0]       checksum_r;
  logic              wr_viol_r;

  logic              wb_req_s;
  logic              is_mem_s;
  logic [OFF_W-1:0]  reg_off_s;
  logic              cpu_go_s;
  logic              wb_mem_go_s;
  logic              wb_drop_s;
  logic              wb_reg_go_s;
  logic              ctrl_apply_s;
  logic [31:0]       status_s;
  logic              unused_s;

  // Holding off acceptance while ack is high prevents a double acknowledge.
  assign wb_req_s     = rst_n & wbs_cyc_i & wbs_stb_i & ~ack_r;
  assign is_mem_s     = ~wbs_adr_i[ADDR_W+2];
  assign reg_off_s    = wbs_adr_i[ADDR_W+1:0];
  assign cpu_go_s     = rst_n & (state_r == ST_RUN) & cpu_rom_req;
  assign ctrl_apply_s = ack_r & ctrl_wr_r;
  assign status_s     = {checksum_r, 13'd0, (state_r == ST_ARM), wr_viol_r, (state_r == ST_RUN)};
  assign unused_s     = ^{wbs_adr_i[31:ADDR_W+3], wbs_dat_i[31:DATA_W]};

  assign wbs_ack_o     = ack_r;
  assign cpu_rom_valid = cpu_valid_r;
  assign cpu_rst_n     = cpu_rst_n_r;

  // Request classification and memory port mux; the CPU always wins in RUN.
  always_comb begin
    wb_mem_go_s = 1'b0;
    wb_drop_s   = 1'b0;
    wb_reg_go_s = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (wb_req_s && !is_mem_s) begin
      wb_reg_go_s = 1'b1;
    end else if (wb_req_s && wbs_we_i && (state_r == ST_RUN)) begin
      wb_drop_s = 1'b1;
    end else if (wb_req_s && !cpu_go_s) begin
      wb_mem_go_s = 1'b1;
    end else begin
      wb_mem_go_s = 1'b0;
    end
    if (cpu_go_s) begin
      mem_en   = 1'b1;
      mem_addr = cpu_rom_addr;
    end else if (wb_mem_go_s) begin
      mem_en    = 1'b1;
      mem_we    = wbs_we_i;
      mem_addr  = wbs_adr_i[ADDR_W+1:2];
      mem_wdata = wbs_dat_i[DATA_W-1:0];
    end else begin
      mem_en = 1'b0;
    end
  end

  // Boot sequencer next state; CTRL writes take effect as they are acknowledged.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (ctrl_apply_s && ctrl_run_r) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_ARM: begin
        if (ctrl_apply_s && !ctrl_run_r) begin
          state_nxt_s = ST_LOAD;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_RUN: begin
        if (ctrl_apply_s && !ctrl_run_r) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Read data is steered straight from the synchronous memory in the ack cycle.
  always_comb begin
    wbs_dat_o = 32'd0;
    if (!ack_r) begin
      wbs_dat_o = 32'd0;
    end else if (rd_mem_r) begin
      wbs_dat_o = {{(32-DATA_W){1'b0}}, mem_rdata};
    end else begin
      wbs_dat_o = reg_rdata_r;
    end
  end

  // Fetch data is only presented alongside a valid fetch.
  always_comb begin
    cpu_rom_data = '0;
    if (cpu_valid_r) begin
      cpu_rom_data = mem_rdata;
    end else begin
      cpu_rom_data = '0;
    end
  end

  // Sequencer state, reset-hold counter and core reset.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_r     <= ST_LOAD;
      hold_cnt_r  <= '0;
      cpu_rst_n_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cpu_rst_n_r <= (state_nxt_s == ST_RUN);
      if ((state_r == ST_ARM) && (state_nxt_s == ST_ARM)) begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1'b1);
      end else begin
        hold_cnt_r <= '0;
      end
    end
  end

  // Acknowledge, register read capture and pending CTRL write.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      ack_r       <= 1'b0;
      rd_mem_r    <= 1'b0;
      reg_rdata_r <= 32'd0;
      ctrl_wr_r   <= 1'b0;
      ctrl_run_r  <= 1'b0;
      ctrl_clr_r  <= 1'b0;
    end else begin
      ack_r     <= wb_mem_go_s | wb_drop_s | wb_reg_go_s;
      rd_mem_r  <= wb_mem_go_s & ~wbs_we_i;
      ctrl_wr_r <= wb_reg_go_s & wbs_we_i & (reg_off_s == OFF_CTRL);
      if (wb_reg_go_s && wbs_we_i && (reg_off_s == OFF_CTRL)) begin
        ctrl_run_r <= wbs_dat_i[0];
        ctrl_clr_r <= wbs_dat_i[1];
      end else begin
        ctrl_run_r <= ctrl_run_r;
        ctrl_clr_r <= ctrl_clr_r;
      end
      if (wb_reg_go_s && !wbs_we_i && (reg_off_s == OFF_CTRL)) begin
        reg_rdata_r <= {31'd0, run_r};
      end else if (wb_reg_go_s && !wbs_we_i && (reg_off_s == OFF_STATUS)) begin
        reg_rdata_r <= status_s;
      end else begin
        reg_rdata_r <= 32'd0;
      end
    end
  end

  // Run bit, checksum and write-violation flag.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      run_r      <= 1'b0;
      checksum_r <= 16'd0;
      wr_viol_r  <= 1'b0;
    end else begin
      if (ctrl_apply_s) begin
        run_r <= ctrl_run_r;
      end else begin
        run_r <= run_r;
      end
      if (ctrl_apply_s && ctrl_clr_r) begin
        checksum_r <= 16'd0;
        wr_viol_r  <= 1'b0;
      end else begin
        if (wb_mem_go_s && wbs_we_i) begin
          checksum_r <= sum_add(checksum_r, wbs_dat_i[DATA_W-1:0]);
        end else begin
          checksum_r <= checksum_r;
        end
        if (wb_drop_s) begin
          wr_viol_r <= 1'b1;
        end else begin
          wr_viol_r <= wr_viol_r;
        end
      end
    end
  end

  // A fetch whose return lands outside RUN is silently dropped.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      cpu_valid_r <= 1'b0;
    end else begin
      cpu_valid_r <= cpu_go_s & (state_nxt_s == ST_RUN);
    end
  end

endmodule

// File: tb/tb_tms_rom_arbiter.sv
// Scoreboard bench for tms_rom_arbiter: directed Wishbone/CPU stimulus pushes expected
// responses into queues; a negedge monitor pops and compares on each ack / valid.
module tb_tms_rom_arbiter;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 8;
  localparam int RST_HOLD = 4;
  localparam logic [31:0] A_CTRL   = 32'h0000_2000;
  localparam logic [31:0] A_STATUS = 32'h0000_2004;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cyc, stb, we;
  logic [31:0]       adr, wdat, rdat;
  logic              ack;
  logic              cpu_rom_req;
  logic [ADDR_W-1:0] cpu_rom_addr;
  logic [DATA_W-1:0] cpu_rom_data;
  logic              cpu_rom_valid, cpu_rst_n;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [7:0]        mem [0:2047];

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic [31:0] wb_q[$];
  string       wb_nm_q[$];
  logic [7:0]  cpu_q[$];
  logic        prot_win = 1'b0;
  logic        we_seen = 1'b0;

  tms_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)) dut (
    .wb_clk_i(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
    .cpu_rom_req(cpu_rom_req), .cpu_rom_addr(cpu_rom_addr),
    .cpu_rom_data(cpu_rom_data), .cpu_rom_valid(cpu_rom_valid), .cpu_rst_n(cpu_rst_n),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Synchronous single-port program memory, read-before-write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) if (prot_win && mem_we) we_seen <= 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every ack and every fetch-valid must match the head of its queue.
  always @(negedge clk) begin
    if (ack) begin
      if (wb_q.size() == 0) chk("wb_unexpected_ack", 32'd1, 32'd0);
      else chk(wb_nm_q.pop_front(), rdat, wb_q.pop_front());
    end
    if (cpu_rom_valid) begin
      if (cpu_q.size() == 0) chk("cpu_unexpected_valid", 32'd1, 32'd0);
      else chk("cpu_fetch_data", {24'd0, cpu_rom_data}, {24'd0, cpu_q.pop_front()});
    end
  end

  // Starts just after a posedge; returns just after the posedge ending the ack cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input string nm, output int ack_cyc);
    int n;
    wb_q.push_back(exp);
    wb_nm_q.push_back(nm);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    n = 0;
    ack_cyc = -1;
    while (n < 64) begin
      @(negedge clk);
      if (ack) begin
        ack_cyc = cyc_cnt;
        break;
      end
      n++;
    end
    if (ack_cyc < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; wdat = 32'd0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_dat_o"}, rdat, 32'd0);
    chk({tag, "_valid"}, {31'd0, cpu_rom_valid}, 32'd0);
    chk({tag, "_cpu_data"}, {24'd0, cpu_rom_data}, 32'd0);
    chk({tag, "_mem_ctl"}, {30'd0, mem_en, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {21'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    int a, c0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; wdat = 32'd0;
    cpu_rom_req = 1'b0; cpu_rom_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load image and verify checksum.
    wb_xfer(1'b1, 32'h0000_0000, 32'h0000_000C, 32'd0, "wr0", a);
    wb_xfer(1'b1, 32'h0000_0004, 32'hFFFF_FFF1, 32'd0, "wr1", a);
    wb_xfer(1'b1, 32'h0000_1FFC, 32'h0000_0025, 32'd0, "wr7ff", a);
    wb_xfer(1'b0, 32'h0000_0000, 32'd0, 32'h0000_000C, "rd0", a);
    wb_xfer(1'b0, 32'h0000_0004, 32'd0, 32'h0000_00F1, "rd1", a);
    wb_xfer(1'b0, 32'h0000_1FFC, 32'd0, 32'h0000_0025, "rd7ff", a);
    wb_xfer(1'b0, A_STATUS, 32'd0, 32'h0122_0000, "status_load", a);
    wb_xfer(1'b0, A_CTRL, 32'd0, 32'h0000_0000, "ctrl_load", a);
    wb_xfer(1'b1, 32'h0000_200C, 32'hFFFF_FFFF, 32'd0, "wr_undef", a);
    wb_xfer(1'b0, 32'h0000_200C, 32'd0, 32'h0000_0000, "rd_undef", a);

    // Release timing: ARM visible from A+1, core released at A+1+RST_HOLD.
    wb_xfer(1'b1, A_CTRL, 32'h0000_0001, 32'd0, "ctrl_run", a);
    fork
      wb_xfer(1'b0, A_STATUS, 32'd0, 32'h0122_0004, "status_arm", c0);
      begin
        for (int k = 1; k <= RST_HOLD + 1; k++) begin
          @(negedge clk);
          chk($sformatf("cpu_rst_n_A+%0d", k), {31'd0, cpu_rst_n},
              (k == RST_HOLD + 1) ? 32'd1 : 32'd0);
        end
      end
    join
    @(posedge clk); #1;
    wb_xfer(1'b0, A_STATUS, 32'd0, 32'h0122_0001, "status_run", a);
    wb_xfer(1'b0, A_CTRL, 32'd0, 32'h0000_0001, "ctrl_rd_run", a);

    // Arbitration: three fetches hold off a pending Wishbone read of address 1.
    cpu_q.push_back(8'h0C); cpu_q.push_back(8'hF1); cpu_q.push_back(8'h25);
    c0 = cyc_cnt;
    fork
      wb_xfer(1'b0, 32'h0000_0004, 32'd0, 32'h0000_00F1, "rd1_collide", a);
      begin
        cpu_rom_req = 1'b1; cpu_rom_addr = 11'h000;
        @(posedge clk); #1; cpu_rom_addr = 11'h001;
        @(posedge clk); #1; cpu_rom_addr = 11'h7FF;
        @(posedge clk); #1; cpu_rom_req = 1'b0; cpu_rom_addr = 11'h000;
      end
    join
    chk("collide_ack_cycle", a, c0 + 4);

    // Write protection in RUN.
    prot_win = 1'b1;
    wb_xfer(1'b1, 32'h0000_0000, 32'h0000_0055, 32'd0, "wr_prot", a);
    prot_win = 1'b0;
    chk("mem_we_in_run", {31'd0, we_seen}, 32'd0);
    wb_xfer(1'b0, A_STATUS, 32'd0, 32'h0122_0003, "status_viol", a);
    wb_xfer(1'b0, 32'h0000_0000, 32'd0, 32'h0000_000C, "rd0_prot", a);
    wb_xfer(1'b1, A_CTRL, 32'h0000_0002, 32'd0, "ctrl_clr", a);
    wb_xfer(1'b0, A_STATUS, 32'd0, 32'h0000_0000, "status_clr", a);
    wb_xfer(1'b1, A_CTRL, 32'h0000_0001, 32'd0, "ctrl_run2", a);
    repeat (RST_HOLD) @(posedge clk);
    @(negedge clk);
    chk("rerun_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    @(posedge clk); #1;

    // Return to LOAD with a fetch issued in the ack cycle.
    c0 = cyc_cnt;
    fork
      wb_xfer(1'b1, A_CTRL, 32'h0000_0000, 32'd0, "ctrl_stop", a);
      begin
        @(posedge clk); #1; cpu_rom_req = 1'b1; cpu_rom_addr = 11'h001;
        @(negedge clk);
        chk("cpu_rst_n_ack_cyc", {31'd0, cpu_rst_n}, 32'd1);
        @(posedge clk); #1; cpu_rom_req = 1'b0;
        @(negedge clk);
        chk("cpu_rst_n_after_ack", {31'd0, cpu_rst_n}, 32'd0);
        chk("inflight_suppressed", {31'd0, cpu_rom_valid}, 32'd0);
      end
    join
    chk("stop_ack_cycle", a, c0 + 1);
    @(posedge clk); #1;
    wb_xfer(1'b1, 32'h0000_0000, 32'h0000_005A, 32'd0, "wr0_reload", a);
    wb_xfer(1'b0, 32'h0000_0000, 32'd0, 32'h0000_005A, "rd0_reload", a);
    wb_xfer(1'b0, A_STATUS, 32'd0, 32'h005A_0000, "status_reload", a);

    // Reset pulse during ARM.
    wb_xfer(1'b1, A_CTRL, 32'h0000_0001, 32'd0, "ctrl_run3", a);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_arm");
    for (int k = 0; k < RST_HOLD + 2; k++) begin
      @(negedge clk);
      chk("post_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    end
    @(posedge clk); #1;
    wb_xfer(1'b0, A_STATUS, 32'd0, 32'h0000_0000, "status_post_rst", a);
    cpu_rom_req = 1'b1; cpu_rom_addr = 11'h001;
    @(negedge clk);
    chk("load_ignores_cpu", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    cpu_rom_req = 1'b0;
    repeat (2) @(negedge clk);

    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("cpu_queue_drained", cpu_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tms_rom_arbiter.md
# tms_rom_arbiter

Owns the TMS1x00 program memory port and sequences the core's boot. The management SoC loads the program image over Wishbone while the core is held in reset, reads it back to verify it, and then releases the core. While the core runs, the block shares the single-port memory between CPU instruction fetches (priority) and Wishbone readback.

## Interface
Parameters:
- ADDR_W, 11, program memory address width (2048 bytes)
- DATA_W, 8, program memory data width
- RST_HOLD, 4, cycles spent in ARM before the CPU is released

Ports:
- wb_clk_i  in  1  clock; sole clock domain
- rst_n  in  1  synchronous, active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic request
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  one-cycle acknowledge
- cpu_rom_req  in  1  CPU fetch request
- cpu_rom_addr  in  ADDR_W  fetch address
- cpu_rom_data  out  DATA_W  fetched byte
- cpu_rom_valid  out  1  fetch data valid
- cpu_rst_n  out  1  active-low reset to the core
- mem_en, mem_we  out  1 each  memory enable and write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous, valid one cycle after mem_en

## Operation
- Address decode:
  - wbs_adr_i[ADDR_W+2]=0 selects the memory window. Word-addressed: the memory address is wbs_adr_i[ADDR_W+1:2] and the data is in bits [DATA_W-1:0].
  - wbs_adr_i[ADDR_W+2]=1 selects the registers. Offset 0x0 is CTRL; offset 0x4 is STATUS.
- CTRL (write) bits:
  - bit0 run
  - bit1 clr_sum
- CTRL (read) returns run in bit0.
- STATUS (read-only) bits:
  - bit0 = 1 in RUN
  - bit1 = wr_viol (sticky)
  - bit2 = 1 in ARM
  - [31:16] = checksum
- States:
  - LOAD (reset state): Wishbone owns the memory and cpu_rom_req is ignored.
  - LOAD→ARM: on a CTRL write with run=1.
  - ARM: RST_HOLD cycles. Memory is Wishbone-owned and cpu_rst_n stays 0. After RST_HOLD cycles, go to RUN.
  - RUN: cpu_rst_n=1. The CPU has priority on the memory. A Wishbone memory access is issued only in a cycle with cpu_rom_req=0; otherwise it waits with ack held low.
  - RUN or ARM→LOAD: on a CTRL write with run=0. cpu_rst_n drops to 0 in the cycle after the ack. An in-flight fetch still returns, but cpu_rom_valid is suppressed.
- Wishbone memory writes:
  - In LOAD or ARM, a write sets checksum += mem_wdata, modulo 2^16.
  - In RUN, a write is dropped (mem_we stays 0), acked normally, and sets wr_viol.
- clr_sum=1 clears checksum and wr_viol. It can be combined with run in the same CTRL write.
- A new Wishbone request is accepted only when cyc&stb=1 and wbs_ack_o=0, so the block never double-acks.
- Writes to undefined register offsets are acked and ignored. Reads of undefined offsets return 0.

## Timing
- Reset values:
  - state LOAD, cpu_rst_n=0
  - wbs_ack_o=0, wbs_dat_o=0
  - cpu_rom_valid=0, cpu_rom_data=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - checksum=0, wr_viol=0
- rst_n=0 mid-ARM or mid-RUN forces all of the above on the next edge. Pending acks and fetches are discarded.
- mem_en, mem_we, mem_addr and mem_wdata are combinational from the granted request in the issue cycle N.
- Wishbone memory access: issued in cycle N, wbs_ack_o=1 in cycle N+1, with read data on wbs_dat_o.
- Register access: acked in cycle N+1 after acceptance.
- CPU fetch: request in cycle N gives cpu_rom_valid=1 and data in cycle N+1. The CPU is never stalled.
- Collision in RUN: the CPU is issued in N and Wishbone in the first later cycle with cpu_rom_req=0.
- Timing of the run=1 write:
  - The CTRL write is acked in cycle A.
  - state=ARM from A+1.
  - cpu_rst_n=1 from A+1+RST_HOLD.

## Test plan
- Load and checksum: in LOAD, write 0x0C, 0xF1 and 0x25 to addresses 0, 1 and 0x7FF, then read them back → 0x0C, 0xF1, 0x25; STATUS[31:16]=0x0122.
- Release timing: write CTRL=1, acked in cycle A → STATUS.bit2=1 from A+1; cpu_rst_n=0 through A+RST_HOLD and =1 at A+1+RST_HOLD; STATUS.bit0=1.
- Arbitration: in RUN, hold cpu_rom_req=1 for 3 cycles while a Wishbone read of address 1 is pending → three cpu_rom_valid pulses with the correct bytes; the Wishbone ack arrives 1 cycle after cpu_rom_req falls, with data 0xF1.
- Write protection: in RUN, write 0x55 to address 0 → acked, mem_we never 1, STATUS.bit1=1, reading address 0 returns 0x0C. A CTRL write of 0x2 then clears STATUS.bit1 and the checksum.
- Return to LOAD: write CTRL=0 while a fetch is in flight → cpu_rst_n=0 in the cycle after the ack; no cpu_rom_valid for the in-flight fetch; a Wishbone write to address 0 now takes effect.
- Reset mid-operation: assert rst_n=0 for 1 cycle during ARM → all outputs return to their reset values, state is LOAD, and cpu_rst_n stays 0.
